// File: rtl/dot_product_accumulator.sv
// Streaming signed dot-product accumulator fed by the multiplier lane over valid/ready.
// Define DOT_ACC_SATURATE_EN to clamp on overflow; otherwise the accumulator wraps.
module dot_product_accumulator #(
    parameter int BITS     = 8,
    parameter int ACC_BITS = 24,
    parameter int LEN_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_BITS-1:0]        length,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITS-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_BITS-1:0] out_data,
    output logic                       busy,
    output logic                       overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    state_t                r_state;
    logic [LEN_BITS-1:0]   r_count;
    logic [ACC_BITS-1:0]   r_acc;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_overflow;

    logic [ACC_BITS:0]     w_data_ext;
    logic [ACC_BITS:0]     w_acc_ext;
    logic [ACC_BITS:0]     w_sum;
    logic                  w_ovf;
    logic [ACC_BITS-1:0]   w_next;

    // One guard bit above the accumulator: a mismatch between the top two bits of the sum is overflow.
    assign w_data_ext = {{(ACC_BITS+1-BITS){in_data[BITS-1]}}, in_data};
    assign w_acc_ext  = {r_acc[ACC_BITS-1], r_acc};
    assign w_sum      = w_acc_ext + w_data_ext;
    assign w_ovf      = w_sum[ACC_BITS] ^ w_sum[ACC_BITS-1];

`ifdef DOT_ACC_SATURATE_EN
    assign w_next = w_ovf ? (w_sum[ACC_BITS] ? ACC_MIN : ACC_MAX) : w_sum[ACC_BITS-1:0];
`else
    assign w_next = w_sum[ACC_BITS-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                        r_count    <= length;
                        r_busy     <= 1'b1;
                        if (length != '0) begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_acc   <= w_next;
                        r_count <= r_count - 1'b1;
                        if (w_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_count == LEN_BITS'(1)) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign busy      = r_busy;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator: a 24-bit and an 8-bit accumulator instance.
// Expected results are pushed at start; monitors pop and compare on each output handshake.
module tb_dot_product_accumulator;

    typedef struct {
        int   data;
        logic ovf;
    } exp_t;

    logic               clk;
    logic               rst_n;

    logic               start;
    logic [7:0]         length;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_data;
    logic               busy;
    logic               overflow;

    logic               start8;
    logic [7:0]         length8;
    logic               in_valid8;
    logic               in_ready8;
    logic signed [7:0]  in_data8;
    logic               out_valid8;
    logic               out_ready8;
    logic signed [7:0]  out_data8;
    logic               busy8;
    logic               overflow8;

    exp_t q[$];
    exp_t q8[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef DOT_ACC_SATURATE_EN
    localparam int EXP_POS = 127;
    localparam int EXP_NEG = -128;
`else
    localparam int EXP_POS = -2;
    localparam int EXP_NEG = 0;
`endif

    dot_product_accumulator #(.BITS(8), .ACC_BITS(24), .LEN_BITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow)
    );

    dot_product_accumulator #(.BITS(8), .ACC_BITS(8), .LEN_BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .length(length8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .busy(busy8), .overflow(overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitors compare each result at the negedge before the edge that accepts it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checkOutput("sb24_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("sb24_data", int'(out_data), e.data);
                checkOutput("sb24_overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checkOutput("sb8_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                checkOutput("sb8_data", int'(out_data8), e.data);
                checkOutput("sb8_overflow", {31'd0, overflow8}, {31'd0, e.ovf});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input int len, input int expData, input logic expOvf);
        exp_t e;
        e.data = expData;
        e.ovf  = expOvf;
        q.push_back(e);
        start  = 1'b1;
        length = 8'(len);
        step();
        start  = 1'b0;
    endtask

    // Cycle counter starts at 1 because the caller is already in the cycle after start.
    task automatic waitValid(input string name, inout int cyc);
        int budget = 50;
        while (!out_valid && budget > 0) begin
            step();
            cyc++;
            budget--;
        end
        if (!out_valid) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic acceptResult();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run8(input int n, input int d0, input int d1, input int expData,
                        input logic expOvf);
        exp_t e;
        int   budget = 50;
        e.data = expData;
        e.ovf  = expOvf;
        q8.push_back(e);
        start8  = 1'b1;
        length8 = 8'(n);
        step();
        start8  = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid8 = 1'b1;
            in_data8  = (i == 0) ? 8'(d0) : 8'(d1);
            step();
        end
        in_valid8 = 1'b0;
        while (!out_valid8 && budget > 0) begin
            step();
            budget--;
        end
        if (!out_valid8) checkOutput("acc8_timeout", 0, 1);
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
    endtask

    task automatic applyStimulus();
        int cyc;
        int vld_pat [5] = '{1, 0, 1, 0, 1};
        int beats   [4] = '{3, -5, 10, -1};

        // Reset values while reset is held.
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_overflow", {31'd0, overflow}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Four back-to-back beats: 3 - 5 + 10 - 1 = 7, valid L+1 cycles after start.
        doStart(4, 7, 1'b0);
        cyc = 1;
        checkOutput("t1_in_ready_after_start", {31'd0, in_ready}, 1);
        checkOutput("t1_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_no_early_valid", {31'd0, out_valid}, 0);
            in_valid = 1'b1;
            in_data  = 8'(beats[i]);
            step();
            cyc++;
        end
        in_valid = 1'b0;
        waitValid("t1", cyc);
        checkOutput("t1_latency", cyc, 5);
        checkOutput("t1_in_ready_done", {31'd0, in_ready}, 0);
        acceptResult();
        checkOutput("t1_idle_out_valid", {31'd0, out_valid}, 0);
        checkOutput("t1_idle_busy", {31'd0, busy}, 0);

        // Gapped valid: only accepted beats count, in_ready stays high in ACCUM.
        doStart(3, 300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_in_ready_held", {31'd0, in_ready}, 1);
            checkOutput("t2_no_early_valid", {31'd0, out_valid}, 0);
            in_valid = vld_pat[i][0];
            in_data  = 8'sd100;
            step();
        end
        in_valid = 1'b0;
        checkOutput("t2_valid_after_third", {31'd0, out_valid}, 1);
        acceptResult();

        // Zero length: immediate result, held stable under backpressure, starts ignored.
        doStart(0, 0, 1'b0);
        checkOutput("t3_valid_next_cycle", {31'd0, out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            start  = 1'b1;
            length = 8'd5;
            step();
            checkOutput("t3_hold_valid", {31'd0, out_valid}, 1);
            checkOutput("t3_hold_data", int'(out_data), 0);
            checkOutput("t3_hold_in_ready", {31'd0, in_ready}, 0);
        end
        start = 1'b0;
        acceptResult();
        checkOutput("t3_back_to_idle", {31'd0, busy}, 0);

        // Narrow accumulator overflow, then sticky flag cleared by the next start.
        run8(2, 127, 127, EXP_POS, 1'b1);
        run8(2, -128, -128, EXP_NEG, 1'b1);
        run8(1, 5, 0, 5, 1'b0);

        // Reset mid-reduction after two of five beats discards everything.
        start  = 1'b1;
        length = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'sd50;
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_in_ready", {31'd0, in_ready}, 0);
        checkOutput("t5_async_out_valid", {31'd0, out_valid}, 0);
        checkOutput("t5_async_out_data", int'(out_data), 0);
        checkOutput("t5_async_busy", {31'd0, busy}, 0);
        checkOutput("t5_async_overflow", {31'd0, overflow}, 0);
        #2 rst_n = 1'b1;
        step();
        doStart(1, -7, 1'b0);
        in_valid = 1'b1;
        in_data  = -8'sd7;
        step();
        in_valid = 1'b0;
        cyc = 0;
        waitValid("t5", cyc);
        acceptResult();

        // Back-to-back reductions with start on the first IDLE cycle.
        doStart(2, 3, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'sd1;
        step();
        in_data  = 8'sd2;
        step();
        in_valid = 1'b0;
        acceptResult();
        doStart(2, -8, 1'b0);
        checkOutput("t6_second_start_taken", {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = -8'sd4;
        step();
        step();
        in_valid = 1'b0;
        cyc = 0;
        waitValid("t6", cyc);
        acceptResult();
        step();

        checkOutput("sb24_drained", q.size(), 0);
        checkOutput("sb8_drained", q8.size(), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        length     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        start8     = 1'b0;
        length8    = '0;
        in_valid8  = 1'b0;
        in_data8   = '0;
        out_ready8 = 1'b0;
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
